cypress_stream_tx: RTL and testbench

Parametrised successor of the single-word Cypress writer. It accepts WORD_W-bit words over a ready/valid stream and buffers them in a DEPTH-word show-ahead FIFO. Each word is serialised into 16-bit FX2 slave-FIFO writes, low half first. It commits short packets with PKTEND at frame end. It sits between the FFT/result formatter and the FX2 GPIF pins, clocked by ifclk.

---
 rtl/cypress_stream_tx_if.sv | 27 ++
 rtl/cypress_stream_tx.sv | 137 +++++++++++++
 tb/tb_cypress_stream_tx.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/cypress_stream_tx_if.sv
// Bundle of the word-stream sink and the FX2 slave-FIFO write pins.
// Latency: none, wires only.
// Backpressure: sink_ready from the slave side, flaga from the FX2 side.
interface cypress_stream_tx_if #(
    parameter int WORD_W = 32
);
    logic [WORD_W-1:0] sink_data;
    logic              sink_valid;
    logic              sink_eop;
    logic              sink_ready;
    logic              flaga;
    logic [15:0]       fd;
    logic              slwr;
    logic              pktend;

    // Producer side plus FX2 status source (bench / upstream).
    modport master (
        output sink_data, sink_valid, sink_eop, flaga,
        input  sink_ready, fd, slwr, pktend
    );

    // The serialiser block.
    modport slave (
        input  sink_data, sink_valid, sink_eop, flaga,
        output sink_ready, fd, slwr, pktend
    );
endinterface

// File: rtl/cypress_stream_tx.sv
// Buffers WORD_W-bit words and writes them to an FX2 slave FIFO as 16-bit halves, low half first; PKTEND on short frames.
// Latency: word accepted on edge E into an idle empty block appears as half 0 after edge E+2.
// Backpressure: sink_ready = level < DEPTH (registered); flaga=0 freezes the writer with slwr high.
module cypress_stream_tx #(
    parameter int WORD_W  = 32,
    parameter int DEPTH   = 8,
    parameter int PKT_LEN = 256
) (
    input  logic                     i_ifclk,
    input  logic                     i_reset,
    cypress_stream_tx_if.slave       io_bus,
    output logic [$clog2(DEPTH):0]   o_level
);
    localparam int NH = WORD_W / 16;
    localparam int AW = $clog2(DEPTH);
    localparam int HW = (NH > 1) ? $clog2(NH) : 1;
    localparam int CW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_PKTEND} state_t;

    state_t            r_state, w_state_nxt;
    logic [WORD_W:0]   r_mem [DEPTH];
    logic [AW-1:0]     r_wptr, r_rptr;
    logic [AW:0]       r_level, w_level_nxt;
    logic              r_sink_ready;
    logic [WORD_W-1:0] r_shift;
    logic              r_eop;
    logic [HW-1:0]     r_half;
    logic [CW-1:0]     r_pkt_cnt, w_cnt_inc;
    logic [15:0]       r_fd;
    logic              r_slwr, r_pktend;

    logic              w_push, w_pop, w_write, w_pkt_fire, w_empty, w_last_half;
    logic [WORD_W:0]   w_head;

    assign w_push      = io_bus.sink_valid & r_sink_ready;
    assign w_empty     = (r_level == '0);
    assign w_head      = r_mem[r_rptr];
    assign w_last_half = (r_half == HW'(NH - 1));
    assign w_cnt_inc   = (r_pkt_cnt == CW'(PKT_LEN - 1)) ? '0 : r_pkt_cnt + CW'(1);
    assign w_level_nxt = r_level + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};

    // Next state and per-edge actions; nothing advances while flaga is low.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_write     = 1'b0;
        w_pkt_fire  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (io_bus.flaga && !w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                if (io_bus.flaga) begin
                    w_write = 1'b1;
                    if (w_last_half) begin
                        if (r_eop)
                            w_state_nxt = (w_cnt_inc != '0) ? S_PKTEND : S_IDLE;
                        else if (!w_empty)
                            w_pop = 1'b1;    // chain the next word, no bubble
                        else
                            w_state_nxt = S_IDLE;
                    end
                end
            end
            S_PKTEND: begin
                if (io_bus.flaga) begin
                    w_pkt_fire  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_ifclk) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    // FIFO storage; contents need no reset since level gates every read.
    always_ff @(posedge i_ifclk) begin
        if (w_push) r_mem[r_wptr] <= {io_bus.sink_eop, io_bus.sink_data};
    end

    // FIFO pointers, occupancy and the registered ready flag.
    always_ff @(posedge i_ifclk) begin
        if (i_reset) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_level      <= '0;
            r_sink_ready <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            r_level      <= w_level_nxt;
            r_sink_ready <= (w_level_nxt < (AW + 1)'(DEPTH));
        end
    end

    // Shift register, half/packet counters and the registered FX2 pins.
    always_ff @(posedge i_ifclk) begin
        if (i_reset) begin
            r_shift   <= '0;
            r_eop     <= 1'b0;
            r_half    <= '0;
            r_pkt_cnt <= '0;
            r_fd      <= '0;
            r_slwr    <= 1'b1;
            r_pktend  <= 1'b1;
        end else begin
            r_slwr   <= ~w_write;
            r_pktend <= ~w_pkt_fire;
            if (w_write) begin
                r_fd      <= r_shift[{r_half, 4'b0000} +: 16];
                r_half    <= w_last_half ? '0 : r_half + HW'(1);
                r_pkt_cnt <= w_cnt_inc;
            end
            if (w_pop) begin
                r_shift <= w_head[WORD_W-1:0];
                r_eop   <= w_head[WORD_W];
                r_half  <= '0;
            end
            if (w_pkt_fire) r_pkt_cnt <= '0;
        end
    end

    assign io_bus.sink_ready = r_sink_ready;
    assign io_bus.fd         = r_fd;
    assign io_bus.slwr       = r_slwr;
    assign io_bus.pktend     = r_pktend;
    assign o_level           = r_level;
endmodule

// File: tb/tb_cypress_stream_tx.sv
// Bench for cypress_stream_tx: directed stimulus, queue-based reference of expected FX2 writes.
// Latency: outputs sampled on the falling edge, inputs driven 1 time unit after the rising edge.
// Backpressure: flaga patterns and a full FIFO are exercised directly.
module tb_cypress_stream_tx;
    localparam int WORD_W  = 32;
    localparam int DEPTH   = 8;
    localparam int PKT_LEN = 4;
    localparam int NH      = WORD_W / 16;
    localparam int LW      = $clog2(DEPTH) + 1;

    typedef struct {
        logic [15:0] d;
        logic        eop_last;
    } half_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [LW-1:0] level;

    always #5 clk = ~clk;

    cypress_stream_tx_if #(.WORD_W(WORD_W)) bus ();

    cypress_stream_tx #(.WORD_W(WORD_W), .DEPTH(DEPTH), .PKT_LEN(PKT_LEN)) dut (
        .i_ifclk (clk),
        .i_reset (rst),
        .io_bus  (bus),
        .o_level (level)
    );

    int    checks = 0;
    int    failures = 0;
    half_t exp_q[$];
    int    pkt_cnt = 0;
    bit    pend = 1'b0;
    int    writes = 0;
    int    pkt_pulses = 0;
    int    run = 0;
    int    max_run = 0;
    logic  rst_prev = 1'b1;
    logic  flaga_prev = 1'b0;
    logic [15:0] prev_fd = 16'h0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, req);
        end
    endtask

    // Reference: expected write stream from accepted words, packet count from observed writes.
    always @(negedge clk) begin
        half_t h;
        if (rst_prev) begin
            chk("rst_fd", bus.fd, 16'h0);
            chk("rst_slwr", bus.slwr, 1'b1);
            chk("rst_pktend", bus.pktend, 1'b1);
            chk("rst_ready", bus.sink_ready, 1'b0);
            chk("rst_level", level, 0);
            exp_q.delete();
            pend = 1'b0;
            pkt_cnt = 0;
            run = 0;
        end else begin
            chk("ready_rule", bus.sink_ready, level < DEPTH);
            chk("slwr_pktend_excl", !bus.slwr && !bus.pktend, 1'b0);
            if (!flaga_prev) chk("slwr_flaga0", bus.slwr, 1'b1);
            chk("pktend", bus.pktend, !(pend && flaga_prev));
            if (!bus.pktend) begin
                pend = 1'b0;
                pkt_cnt = 0;
                pkt_pulses++;
            end
            if (bus.slwr) begin
                chk("fd_hold", bus.fd, prev_fd);
                run = 0;
            end else begin
                writes++;
                run++;
                if (run > max_run) max_run = run;
                chk("write_expected", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) begin
                    h = exp_q.pop_front();
                    chk("fd_data", bus.fd, h.d);
                    pkt_cnt = (pkt_cnt + 1) % PKT_LEN;
                    if (h.eop_last) pend = (pkt_cnt != 0);
                end
            end
        end
        if (!rst && bus.sink_valid && bus.sink_ready)
            for (int i = 0; i < NH; i++)
                exp_q.push_back(half_t'{d: bus.sink_data[16*i +: 16], eop_last: bus.sink_eop && (i == NH - 1)});
        rst_prev   = rst;
        flaga_prev = bus.flaga;
        prev_fd    = bus.fd;
    end

    task automatic push_word(input logic [WORD_W-1:0] d, input logic e, output int stalls);
        bus.sink_data  = d;
        bus.sink_eop   = e;
        bus.sink_valid = 1'b1;
        stalls = 0;
        @(negedge clk);
        while (!bus.sink_ready && stalls < 100) begin
            stalls++;
            @(negedge clk);
        end
        if (!bus.sink_ready) chk("push_timeout", bus.sink_ready, 1'b1);
        @(posedge clk);
        #1 bus.sink_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (n < 300 && !(exp_q.size() == 0 && !pend && bus.slwr && bus.pktend)) begin
            n++;
            @(negedge clk);
        end
        if (n >= 300) chk("drain_timeout", exp_q.size(), 0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (cycles) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, failures=%0d", failures);
        $fatal(1);
    end

    initial begin
        int st, tot, w0, p0, n;
        logic fpat [6];
        bus.sink_data = '0; bus.sink_valid = 1'b0; bus.sink_eop = 1'b0; bus.flaga = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Single word: latency and half order.
        push_word(32'hAAAA5555, 1'b0, st);
        repeat (3) @(negedge clk);
        chk("t1_first_slwr", bus.slwr, 1'b0);
        chk("t1_first_fd", bus.fd, 16'h5555);
        @(negedge clk);
        chk("t1_second_slwr", bus.slwr, 1'b0);
        chk("t1_second_fd", bus.fd, 16'hAAAA);
        @(negedge clk);
        chk("t1_after_slwr", bus.slwr, 1'b1);
        chk("t1_pktend", bus.pktend, 1'b1);
        wait_idle();

        // Ten words at one per NH cycles: continuous writes, ready never drops.
        w0 = writes; max_run = 0; tot = 0;
        for (int i = 0; i < 10; i++) begin
            push_word({16'(16'hB100 + i), 16'(16'hB000 + i)}, 1'b0, st);
            tot += st;
            @(posedge clk);
            #1;
        end
        wait_idle();
        chk("t2_ready_stalls", tot, 0);
        chk("t2_max_run", max_run, 2 * 10);
        chk("t2_writes", writes - w0, 2 * 10);

        // flaga low: fill to DEPTH, ninth word blocked, then drain.
        bus.flaga = 1'b0;
        w0 = writes;
        for (int i = 0; i < 8; i++) push_word({16'(16'hC100 + i), 16'(16'hC000 + i)}, 1'b0, st);
        bus.sink_data = 32'hC108C008; bus.sink_eop = 1'b0; bus.sink_valid = 1'b1;
        repeat (2) @(negedge clk);
        chk("t3_ready_full", bus.sink_ready, 1'b0);
        chk("t3_level_full", level, 8);
        chk("t3_slwr_idle", bus.slwr, 1'b1);
        @(posedge clk);
        #1 bus.flaga = 1'b1;
        push_word(32'hC108C008, 1'b0, st);
        wait_idle();
        chk("t3_writes", writes - w0, 18);

        // flaga toggling during a word.
        w0 = writes;
        fpat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        push_word(32'hC0DEF00D, 1'b0, st);
        for (int i = 0; i < 6; i++) begin
            bus.flaga = fpat[i];
            @(posedge clk);
            #1;
        end
        bus.flaga = 1'b1;
        wait_idle();
        chk("t4_writes", writes - w0, 2);

        // Short packet: 6 writes then one PKTEND; 4 writes hits PKT_LEN, no PKTEND.
        do_reset(2);
        w0 = writes; p0 = pkt_pulses;
        push_word(32'h22221111, 1'b0, st);
        push_word(32'h44443333, 1'b0, st);
        push_word(32'h66665555, 1'b1, st);
        wait_idle();
        chk("t5a_writes", writes - w0, 6);
        chk("t5a_pktend", pkt_pulses - p0, 1);
        w0 = writes; p0 = pkt_pulses;
        push_word(32'h88887777, 1'b0, st);
        push_word(32'hAAAA9999, 1'b1, st);
        wait_idle();
        chk("t5b_writes", writes - w0, 4);
        chk("t5b_pktend", pkt_pulses - p0, 0);

        // Reset mid-word: everything discarded, packet count restarts.
        push_word(32'hDEAD0001, 1'b0, st);
        push_word(32'hDEAD0002, 1'b0, st);
        n = 0;
        while (bus.slwr && n < 20) begin n++; @(negedge clk); end
        chk("t6_write_started", bus.slwr, 1'b0);
        do_reset(1);
        @(negedge clk);
        chk("t6_level_after", level, 0);
        chk("t6_slwr_after", bus.slwr, 1'b1);
        w0 = writes; p0 = pkt_pulses;
        push_word(32'hBEEFCAFE, 1'b0, st);
        push_word(32'h12345678, 1'b1, st);
        wait_idle();
        chk("t6_writes", writes - w0, 4);
        chk("t6_pktend", pkt_pulses - p0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
